// File: rtl/inv_sub_column_if.sv
// inv_sub_column_if
//   Handshake bundle for the inverse SubColumn layer.
//   Ports (signals):
//     in_valid  : producer -> block, data_in is valid
//     in_ready  : block -> producer, block can accept a state
//     data_in   : producer -> block, 64-bit state, row r at [16r+15:16r]
//     out_valid : block -> consumer, data_out holds a finished result
//     out_ready : consumer -> block, result accepted
//     data_out  : block -> consumer, substituted state
//   Modports: slave (the block), master (the environment driving it).
interface inv_sub_column_if;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] data_in;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] data_out;

  modport slave (
    input  in_valid, data_in, out_ready,
    output in_ready, out_valid, data_out
  );

  modport master (
    output in_valid, data_in, out_ready,
    input  in_ready, out_valid, data_out
  );
endinterface

// File: rtl/inv_sub_column.sv
// inv_sub_column
//   Sequential inverse RECTANGLE SubColumn layer. Loads a 64-bit state and
//   applies the inverse S-box to COLS_PER_CYCLE of the 16 columns per clock,
//   in place, then presents the result until the consumer takes it.
//   Column j is {row3[j], row2[j], row1[j], row0[j]}, row r = state[16r+15:16r].
//   Ports:
//     clk    : clock, rising edge
//     rst    : asynchronous active-high reset
//     sub_if : handshake bundle (slave modport)
//   Parameter COLS_PER_CYCLE: 1, 2, 4, 8 or 16; latency is 16/COLS_PER_CYCLE.
module inv_sub_column #(
  parameter int COLS_PER_CYCLE = 4
) (
  input  logic            clk,
  input  logic            rst,
  inv_sub_column_if.slave sub_if
);

  localparam int NCYC = 16 / COLS_PER_CYCLE;
  localparam int GW   = (NCYC > 1) ? $clog2(NCYC) : 1;
  localparam logic [GW-1:0] GRP_LAST = GW'(NCYC - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t        state_q, state_d;
  logic [GW-1:0] grp_q, grp_d;
  logic [63:0]   work_q, work_d;

  logic [3:0]    slot_nib [COLS_PER_CYCLE];
  logic [3:0]    col_next [16];
  logic [63:0]   work_sub;

  function automatic logic [3:0] inv_sbox(input logic [3:0] x);
    case (x)
      4'h0: inv_sbox = 4'h9;  4'h1: inv_sbox = 4'h4;
      4'h2: inv_sbox = 4'hF;  4'h3: inv_sbox = 4'hA;
      4'h4: inv_sbox = 4'hE;  4'h5: inv_sbox = 4'h1;
      4'h6: inv_sbox = 4'h0;  4'h7: inv_sbox = 4'h6;
      4'h8: inv_sbox = 4'hC;  4'h9: inv_sbox = 4'h7;
      4'hA: inv_sbox = 4'h3;  4'hB: inv_sbox = 4'h8;
      4'hC: inv_sbox = 4'h2;  4'hD: inv_sbox = 4'hB;
      4'hE: inv_sbox = 4'h5;  default: inv_sbox = 4'hD;
    endcase
  endfunction

  // One S-box per slot; slot gi serves column grp*COLS_PER_CYCLE+gi, so only
  // COLS_PER_CYCLE S-boxes exist and each is fed through a column mux.
  genvar gi;
  generate
    for (gi = 0; gi < COLS_PER_CYCLE; gi++) begin : g_slot
      logic [5:0] cidx;
      assign cidx = {2'b00, 4'(int'(grp_q) * COLS_PER_CYCLE + gi)};
      assign slot_nib[gi] = inv_sbox({work_q[cidx + 6'd48], work_q[cidx + 6'd32],
                                      work_q[cidx + 6'd16], work_q[cidx]});
    end

    // Each column takes its slot's result only while its group is active.
    for (gi = 0; gi < 16; gi++) begin : g_col
      localparam int SLOT = gi % COLS_PER_CYCLE;
      localparam int GRP  = gi / COLS_PER_CYCLE;
      assign col_next[gi] = (grp_q == GW'(GRP)) ? slot_nib[SLOT]
                          : {work_q[48+gi], work_q[32+gi], work_q[16+gi], work_q[gi]};
      assign work_sub[gi]    = col_next[gi][0];
      assign work_sub[16+gi] = col_next[gi][1];
      assign work_sub[32+gi] = col_next[gi][2];
      assign work_sub[48+gi] = col_next[gi][3];
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      grp_q   <= '0;
      work_q  <= '0;
    end else begin
      state_q <= state_d;
      grp_q   <= grp_d;
      work_q  <= work_d;
    end
  end

  always_comb begin
    state_d = state_q;
    grp_d   = grp_q;
    work_d  = work_q;
    case (state_q)
      IDLE: begin
        if (sub_if.in_valid) begin
          work_d  = sub_if.data_in;
          grp_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        work_d = work_sub;
        if (grp_q == GRP_LAST) state_d = DONE;
        else                   grp_d   = grp_q + 1'b1;
      end
      DONE: begin
        if (sub_if.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs decode registered state only.
  assign sub_if.in_ready  = (state_q == IDLE);
  assign sub_if.out_valid = (state_q == DONE);
  assign sub_if.data_out  = work_q;

endmodule

// File: tb/tb_inv_sub_column.sv
module tb_inv_sub_column;
  localparam int NDUT = 5;
  localparam int CPC_TAB [NDUT] = '{1, 2, 4, 8, 16};

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        in_valid_a  [NDUT];
  logic [63:0] data_in_a   [NDUT];
  logic        out_ready_a [NDUT];
  logic        in_ready_a  [NDUT];
  logic        out_valid_a [NDUT];
  logic [63:0] data_out_a  [NDUT];

  int pass_cnt = 0;
  int chk_cnt  = 0;

  genvar gi;
  generate
    for (gi = 0; gi < NDUT; gi++) begin : g_dut
      inv_sub_column_if u_if ();
      assign u_if.in_valid   = in_valid_a[gi];
      assign u_if.data_in    = data_in_a[gi];
      assign u_if.out_ready  = out_ready_a[gi];
      assign in_ready_a[gi]  = u_if.in_ready;
      assign out_valid_a[gi] = u_if.out_valid;
      assign data_out_a[gi]  = u_if.data_out;
      inv_sub_column #(.COLS_PER_CYCLE(CPC_TAB[gi])) u_dut (
        .clk    (clk),
        .rst    (rst),
        .sub_if (u_if.slave)
      );
    end
  endgenerate

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Forward RECTANGLE column S-box, used only to build round-trip stimulus.
  function automatic logic [63:0] fwd_state(input logic [63:0] s);
    logic [3:0] fwd [16];
    logic [3:0] n, m;
    logic [63:0] r;
    fwd = '{4'h6, 4'h5, 4'hC, 4'hA, 4'h1, 4'hE, 4'h7, 4'h9,
            4'hB, 4'h0, 4'h3, 4'hD, 4'h8, 4'hF, 4'h4, 4'h2};
    r = '0;
    for (int j = 0; j < 16; j++) begin
      n = {s[48+j], s[32+j], s[16+j], s[j]};
      m = fwd[n];
      r[j] = m[0]; r[16+j] = m[1]; r[32+j] = m[2]; r[48+j] = m[3];
    end
    return r;
  endfunction

  // Accept din, wait (bounded) for the result, then hand it off.
  task automatic run_op(input int d, input logic [63:0] din, output logic [63:0] dout,
                        output int lat, output logic ir_seen);
    ir_seen = 1'b0;
    in_valid_a[d] = 1'b1;
    data_in_a[d]  = din;
    @(posedge clk); #1;
    in_valid_a[d] = 1'b0;
    lat = 0;
    while (!out_valid_a[d] && lat < 64) begin
      if (in_ready_a[d]) ir_seen = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    if (in_ready_a[d]) ir_seen = 1'b1;
    dout = data_out_a[d];
    out_ready_a[d] = 1'b1;
    @(posedge clk); #1;
    out_ready_a[d] = 1'b0;
    $display("op dut=%0d cpc=%0d in=%h out=%h lat=%0d", d, CPC_TAB[d], din, dout, lat);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [63:0] dout, orig, hold;
    int lat, wcnt;
    logic ir;
    logic [63:0] vec_in  [3];
    logic [63:0] vec_out [3];
    vec_in  = '{64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFF00_F0F0_CCCC_AAAA};
    vec_out = '{64'hFFFF_0000_0000_FFFF, 64'hFFFF_FFFF_0000_FFFF, 64'hA91D_C396_369C_E625};

    for (int d = 0; d < NDUT; d++) begin
      in_valid_a[d] = 1'b0; data_in_a[d] = '0; out_ready_a[d] = 1'b0;
    end
    #12;
    check("rst_in_ready", in_ready_a[2], 1);
    check("rst_out_valid", out_valid_a[2], 0);
    check("rst_data_out", data_out_a[2], 64'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed vectors on every parallelism.
    for (int d = 0; d < NDUT; d++) begin
      for (int v = 0; v < 3; v++) begin
        run_op(d, vec_in[v], dout, lat, ir);
        check($sformatf("vec%0d_data_d%0d", v, d), dout, vec_out[v]);
        check($sformatf("vec%0d_lat_d%0d", v, d), 64'(lat), 64'(16 / CPC_TAB[d]));
        check($sformatf("vec%0d_busy_rdy_d%0d", v, d), ir, 0);
        check($sformatf("vec%0d_idle_rdy_d%0d", v, d), in_ready_a[d], 1);
      end
    end

    // Round trip through the forward model.
    for (int i = 0; i < 1000; i++) begin
      int d;
      d = i % NDUT;
      orig = {$urandom, $urandom};
      run_op(d, fwd_state(orig), dout, lat, ir);
      check("rt_data", dout, orig);
      check("rt_busy_rdy", ir, 0);
    end

    // Backpressure in DONE with in_valid toggling.
    in_valid_a[2] = 1'b1; data_in_a[2] = 64'h0;
    @(posedge clk); #1;
    in_valid_a[2] = 1'b0;
    wcnt = 0;
    while (!out_valid_a[2] && wcnt < 64) begin @(posedge clk); #1; wcnt++; end
    check("bp_reach_done", out_valid_a[2], 1);
    hold = 64'hFFFF_0000_0000_FFFF;
    for (int c = 0; c < 10; c++) begin
      in_valid_a[2] = c[0];
      data_in_a[2]  = {$urandom, $urandom};
      @(posedge clk); #1;
      check("bp_data", data_out_a[2], hold);
      check("bp_valid", out_valid_a[2], 1);
      check("bp_in_ready", in_ready_a[2], 0);
    end
    in_valid_a[2] = 1'b0;
    out_ready_a[2] = 1'b1;
    @(posedge clk); #1;
    out_ready_a[2] = 1'b0;
    check("bp_release_valid", out_valid_a[2], 0);
    check("bp_release_rdy", in_ready_a[2], 1);
    for (int c = 0; c < 3; c++) begin
      out_ready_a[2] = 1'b1;
      @(posedge clk); #1;
      check("idle_valid", out_valid_a[2], 0);
      check("idle_rdy", in_ready_a[2], 1);
    end
    out_ready_a[2] = 1'b0;
    $display("op dut=2 backpressure hold=%h", hold);

    // Reset mid-BUSY.
    in_valid_a[2] = 1'b1; data_in_a[2] = 64'h0;
    @(posedge clk); #1;
    in_valid_a[2] = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #2;
    check("mid_pre_rdy", in_ready_a[2], 0);
    rst = 1'b1;
    #1;
    check("mid_rst_rdy", in_ready_a[2], 1);
    check("mid_rst_valid", out_valid_a[2], 0);
    check("mid_rst_data", data_out_a[2], 64'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    run_op(2, 64'h0, dout, lat, ir);
    check("post_rst_data", dout, 64'hFFFF_0000_0000_FFFF);
    check("post_rst_lat", 64'(lat), 64'd4);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule

// File: doc/inv_sub_column.md
# inv_sub_column

Sequential inverse SubColumn layer for the RECTANGLE decryption datapath. It takes a 64-bit cipher state and applies the inverse RECTANGLE S-box to each of the 16 four-bit columns, processing COLS_PER_CYCLE columns per clock. It sits between inverse ShiftRow and AddRoundKey in the decryption round and undoes the forward column S-box.

## Interface
- COLS_PER_CYCLE, 4, number of columns substituted per clock. Legal values are 1, 2, 4, 8 and 16. NCYC = 16/COLS_PER_CYCLE.
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  data_in is valid.
- in_ready  out  1  block can accept a state.
- data_in  in  64  input state. Row r occupies bits [16r+15:16r].
- out_valid  out  1  data_out holds a finished result.
- out_ready  in  1  consumer accepts the result.
- data_out  out  64  substituted state, same row layout as data_in.

## Operation
- Column j (0..15) is the nibble {row3[j], row2[j], row1[j], row0[j]}. row0 is the LSB.
- Inverse S-box, input->output (hex): 0->9, 1->4, 2->F, 3->A, 4->E, 5->1, 6->0, 7->6, 8->C, 9->7, A->3, B->8, C->2, D->B, E->5, F->D.
- Internal registers:
  - 64-bit working state.
  - Group counter grp, width ceil(log2(NCYC)), minimum 1 bit.
  - FSM with states IDLE, BUSY and DONE.
- IDLE:
  - in_ready=1, out_valid=0.
  - When in_valid is high, load data_in into the working state, clear grp to 0 and go to BUSY.
- BUSY:
  - in_ready=0.
  - Each cycle, substitute columns grp*COLS_PER_CYCLE through grp*COLS_PER_CYCLE+COLS_PER_CYCLE-1 in place. All other columns keep their values.
  - If grp==NCYC-1, go to DONE. Otherwise increment grp.
- DONE:
  - out_valid=1, in_ready=0.
  - data_out equals the working state and stays stable until the handshake.
  - When out_ready is high, go to IDLE.
- data_out is driven directly from the working state. In IDLE and BUSY its value is don't-care for the consumer, but it must never be X after reset.
- in_valid asserted outside IDLE is ignored. No state is captured and nothing is dropped silently, because in_ready is low.
- out_ready asserted outside DONE is ignored.
- No overlap: a new state is accepted only after the result has been consumed. There is no same-cycle DONE->accept.

## Timing
- Reset (asynchronous, any cycle including mid-BUSY or DONE):
  - FSM=IDLE, grp=0, working state=0.
  - in_ready=1, out_valid=0, data_out=64'h0.
  - Any in-flight operation is discarded.
- Accept on rising edge t (IDLE, in_valid=1).
- BUSY spans the edges t+1 through t+NCYC.
- out_valid rises after edge t+NCYC. Latency from accept is NCYC cycles: 4 at the default, 1 with COLS_PER_CYCLE=16.
- Result consumed on the first edge with out_valid and out_ready both high. in_ready is 1 after that edge.
- Minimum initiation interval is NCYC+2 cycles, with out_ready held high.
- Backpressure: DONE holds indefinitely. data_out and out_valid must not change while out_ready=0.
- All outputs are registered or decoded from FSM state only. There is no combinational path from inputs to outputs.

## Test plan
- data_in=64'h0, out_ready=1 -> out_valid exactly 4 cycles after accept, data_out=64'hFFFF00000000FFFF.
- data_in=64'hFFFFFFFFFFFFFFFF -> data_out=64'hFFFFFFFF0000FFFF. Repeat with COLS_PER_CYCLE=1, 2, 8 and 16 -> same data, latency 16, 8, 2 and 1 respectively.
- Round trip: 1000 random states, each passed through the forward column S-box model and then this block -> data_out equals the original state every time. in_ready must be 0 during BUSY and DONE.
- Backpressure and ignored input:
  - Stimulus: hold out_ready=0 for 10 cycles in DONE while toggling in_valid with new data.
  - Required: data_out and out_valid stay stable and in_ready=0 throughout.
  - On release, exactly one handshake occurs, then IDLE.
- Reset mid-operation: assert rst at cycle 2 of BUSY -> outputs go immediately to in_ready=1, out_valid=0, data_out=0. After release, a fresh accept of 64'h0 produces 64'hFFFF00000000FFFF with normal latency.
